// File: rtl/nasti_dma_mover.sv
// NASTI (AXI4) data mover: copies `length` bytes from src to dest one burst at a time,
// staging each read burst in a local buffer before writing it back out.
module nasti_dma_mover #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    en,
    input  logic [ADDR_WIDTH-1:0]   src_addr,
    input  logic [ADDR_WIDTH-1:0]   dest_addr,
    input  logic [ADDR_WIDTH-1:0]   length,
    output logic                    done,
    output logic                    err,
    output logic [2:0]              state_dbg,
    output logic                    ar_valid,
    input  logic                    ar_ready,
    output logic [ADDR_WIDTH-1:0]   ar_addr,
    output logic [7:0]              ar_len,
    output logic [2:0]              ar_size,
    output logic [1:0]              ar_burst,
    input  logic                    r_valid,
    output logic                    r_ready,
    input  logic [DATA_WIDTH-1:0]   r_data,
    input  logic [1:0]              r_resp,
    input  logic                    r_last,
    output logic                    aw_valid,
    input  logic                    aw_ready,
    output logic [ADDR_WIDTH-1:0]   aw_addr,
    output logic [7:0]              aw_len,
    output logic [2:0]              aw_size,
    output logic [1:0]              aw_burst,
    output logic                    w_valid,
    input  logic                    w_ready,
    output logic [DATA_WIDTH-1:0]   w_data,
    output logic [DATA_WIDTH/8-1:0] w_strb,
    output logic                    w_last,
    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic [1:0]              b_resp
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SHIFT = $clog2(BYTES);
    localparam int NW    = $clog2(MAX_BURST) + 1;
    localparam int IW    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    // Handshake rule: a transfer happens on a rising aclk edge where valid and ready are
    // both high; a raised valid is held, payload stable, until then. Every output below is
    // decoded from registers only, so no input reaches an output combinationally.
    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B} state_t;
    state_t state, state_nx;

    logic [ADDR_WIDTH-1:0] src_q, dest_q, rem_q;
    logic [NW-1:0]         n_q, idx_q;
    logic                  err_q, zero_q;
    logic [DATA_WIDTH-1:0] buf_mem [MAX_BURST];

    logic [ADDR_WIDTH-1:0] src_al, dest_al, beats_in, step, src_nx, dest_nx, rem_nx;
    logic                  last_idx, r_bad, start;

    // Beats in the next burst: bounded by what is left, the buffer and both 4 KiB pages.
    function automatic logic [NW-1:0] calc_n(input logic [11:0] s_lo, input logic [11:0] d_lo,
                                             input logic [ADDR_WIDTH-1:0] rem);
        logic [ADDR_WIDTH-1:0] m, s_room, d_room;
        s_room = ADDR_WIDTH'(13'h1000 - {1'b0, s_lo}) >> SHIFT;
        d_room = ADDR_WIDTH'(13'h1000 - {1'b0, d_lo}) >> SHIFT;
        m = ADDR_WIDTH'(MAX_BURST);
        if (rem < m)    m = rem;
        if (s_room < m) m = s_room;
        if (d_room < m) m = d_room;
        return NW'(m);
    endfunction

    assign src_al   = src_addr & ~ADDR_WIDTH'(BYTES - 1);
    assign dest_al  = dest_addr & ~ADDR_WIDTH'(BYTES - 1);
    assign beats_in = length >> SHIFT;
    assign step     = ADDR_WIDTH'(n_q) << SHIFT;
    assign src_nx   = src_q + step;
    assign dest_nx  = dest_q + step;
    assign rem_nx   = rem_q - ADDR_WIDTH'(n_q);
    assign last_idx = (idx_q == n_q - NW'(1));
    assign start    = en && !zero_q;
    // A bad read beat is an error response or an r_last that disagrees with the burst size.
    assign r_bad    = (r_resp != 2'b00) || (r_last != last_idx);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start && beats_in != '0) state_nx = S_AR;
            S_AR:   if (ar_ready) state_nx = S_R;
            S_R:    if (r_valid && r_last) state_nx = (err_q || r_bad) ? S_IDLE : S_AW;
            S_AW:   if (aw_ready) state_nx = S_W;
            S_W:    if (w_ready && last_idx) state_nx = S_B;
            S_B:    if (b_valid) state_nx = (b_resp != 2'b00 || rem_nx == '0) ? S_IDLE : S_AR;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= S_IDLE;
            src_q  <= '0;
            dest_q <= '0;
            rem_q  <= '0;
            n_q    <= '0;
            idx_q  <= '0;
            err_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            state  <= state_nx;
            zero_q <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    src_q  <= src_al;
                    dest_q <= dest_al;
                    rem_q  <= beats_in;
                    err_q  <= 1'b0;
                    n_q    <= calc_n(src_al[11:0], dest_al[11:0], beats_in);
                    zero_q <= (beats_in == '0);
                end
                S_AR: if (ar_ready) idx_q <= '0;
                S_R: if (r_valid) begin
                    if (r_bad) err_q <= 1'b1;
                    idx_q <= r_last ? '0 : idx_q + NW'(1);
                end
                S_W: if (w_ready) idx_q <= idx_q + NW'(1);
                S_B: if (b_valid) begin
                    if (b_resp != 2'b00) begin
                        err_q <= 1'b1;
                    end else begin
                        src_q  <= src_nx;
                        dest_q <= dest_nx;
                        rem_q  <= rem_nx;
                        n_q    <= calc_n(src_nx[11:0], dest_nx[11:0], rem_nx);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (state == S_R && r_valid) buf_mem[idx_q[IW-1:0]] <= r_data;
    end

    // zero_q holds done low for the single cycle of a zero-beat command.
    assign done      = (state == S_IDLE) && !zero_q;
    assign err       = err_q;
    assign state_dbg = state;

    assign ar_valid = (state == S_AR);
    assign ar_addr  = ar_valid ? src_q : '0;
    assign ar_len   = ar_valid ? 8'(n_q - NW'(1)) : 8'd0;
    assign ar_size  = ar_valid ? 3'(SHIFT) : 3'd0;
    assign ar_burst = ar_valid ? 2'b01 : 2'b00;
    assign r_ready  = (state == S_R);

    assign aw_valid = (state == S_AW);
    assign aw_addr  = aw_valid ? dest_q : '0;
    assign aw_len   = aw_valid ? 8'(n_q - NW'(1)) : 8'd0;
    assign aw_size  = aw_valid ? 3'(SHIFT) : 3'd0;
    assign aw_burst = aw_valid ? 2'b01 : 2'b00;

    assign w_valid  = (state == S_W);
    assign w_data   = w_valid ? buf_mem[idx_q[IW-1:0]] : '0;
    assign w_strb   = w_valid ? '1 : '0;
    assign w_last   = w_valid && last_idx;
    assign b_ready  = (state == S_B);
endmodule

// File: tb/tb_nasti_dma_mover.sv
// Bench for nasti_dma_mover: a reactive memory slave returns beat-index data and a
// scoreboard checks each AR/AW/W handshake against hand-computed expectations.
module tb_nasti_dma_mover;
    logic        aclk = 1'b0;
    logic        aresetn, en;
    logic [63:0] src_addr, dest_addr, length;
    logic        done, err;
    logic [2:0]  state_dbg;
    logic        ar_valid, ar_ready, r_valid, r_ready, r_last;
    logic        aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
    logic [63:0] ar_addr, aw_addr, r_data, w_data;
    logic [7:0]  ar_len, aw_len, w_strb;
    logic [2:0]  ar_size, aw_size;
    logic [1:0]  ar_burst, aw_burst, r_resp, b_resp;

    nasti_dma_mover dut (
        .aclk(aclk), .aresetn(aresetn), .en(en), .src_addr(src_addr), .dest_addr(dest_addr),
        .length(length), .done(done), .err(err), .state_dbg(state_dbg),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
        .ar_size(ar_size), .ar_burst(ar_burst),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
        .aw_size(aw_size), .aw_burst(aw_burst),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
    );

    // Clock and cycle counter
    always #5 aclk = ~aclk;
    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // Scoreboard
    logic [71:0] exp_ar_q[$];
    logic [71:0] exp_aw_q[$];
    logic [64:0] exp_w_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int b_cyc    = -1;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void push_w(int base, int cnt);
        for (int i = 0; i < cnt; i++) exp_w_q.push_back({i == cnt - 1, 64'(base + i)});
    endfunction

    // Monitor: handshakes seen at negedge complete on the following posedge.
    logic [71:0] e72;
    logic [64:0] e65;
    always @(negedge aclk) begin
        if (ar_valid && ar_ready) begin
            e72 = (exp_ar_q.size() > 0) ? exp_ar_q.pop_front() : 72'hdead;
            chk("ar_addr_len", {ar_addr, ar_len}, e72);
            chk("ar_size_burst", {ar_size, ar_burst}, {3'd3, 2'd1});
        end
        if (aw_valid && aw_ready) begin
            e72 = (exp_aw_q.size() > 0) ? exp_aw_q.pop_front() : 72'hdead;
            chk("aw_addr_len", {aw_addr, aw_len}, e72);
            chk("aw_size_burst", {aw_size, aw_burst}, {3'd3, 2'd1});
        end
        if (w_valid && w_ready) begin
            e65 = (exp_w_q.size() > 0) ? exp_w_q.pop_front() : 65'h1dead;
            chk("w_last_data", {w_last, w_data}, e65);
            chk("w_strb", w_strb, 8'hff);
        end
        if (b_valid && b_ready) b_cyc = cyc + 1;
    end

    // Memory slave: read data is the beat index relative to the command's source.
    bit          bp = 1'b0;
    logic [63:0] cmd_src = '0;
    int          rd_beats = 0;
    int          err_beat = -1;
    logic [71:0] rd_q[$];
    logic [71:0] cap_ar, t72;
    logic [63:0] r_base;
    logic [7:0]  r_len, r_idx;
    logic        r_busy, b_pend, f_ar, f_r, f_w, f_b;

    initial begin
        ar_ready = 0; aw_ready = 0; w_ready = 0; r_valid = 0; b_valid = 0;
        r_data = '0; r_resp = '0; r_last = 0; b_resp = '0;
        r_busy = 0; b_pend = 0; r_base = '0; r_len = '0; r_idx = '0;
        forever begin
            @(negedge aclk);
            f_ar = ar_valid && ar_ready;
            cap_ar = {ar_addr, ar_len};
            f_r = r_valid && r_ready;
            f_w = w_valid && w_ready && w_last;
            f_b = b_valid && b_ready;
            @(posedge aclk);
            #1;
            if (!aresetn) begin
                rd_q.delete();
                r_busy = 0; b_pend = 0;
                ar_ready = 0; aw_ready = 0; w_ready = 0; r_valid = 0; b_valid = 0;
            end else begin
                if (f_ar) rd_q.push_back(cap_ar);
                if (f_r) begin
                    rd_beats++;
                    r_valid = 0;
                    if (r_idx == r_len) r_busy = 0;
                    else r_idx++;
                end
                if (!r_valid) begin
                    if (!r_busy && rd_q.size() > 0) begin
                        t72 = rd_q.pop_front();
                        r_base = t72[71:8]; r_len = t72[7:0]; r_idx = '0; r_busy = 1;
                    end
                    if (r_busy && (!bp || $urandom_range(0, 1) == 1)) begin
                        r_valid = 1;
                        r_data  = ((r_base - cmd_src) >> 3) + 64'(r_idx);
                        r_last  = (r_idx == r_len);
                        r_resp  = (rd_beats == err_beat) ? 2'd2 : 2'd0;
                    end
                end
                ar_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
                aw_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
                w_ready  = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
                if (f_w) b_pend = 1;
                if (f_b) b_valid = 0;
                if (b_pend && !b_valid && (!bp || $urandom_range(0, 1) == 1)) begin
                    b_valid = 1; b_resp = 2'd0; b_pend = 0;
                end
            end
        end
    end

    // Driver: issue one command and wait (bounded) for done.
    task automatic run_cmd(input logic [63:0] s, input logic [63:0] d, input logic [63:0] l,
                           output int t1, output int done_cyc);
        int k;
        cmd_src = s & ~64'h7;
        src_addr = s; dest_addr = d; length = l; en = 1;
        @(posedge aclk); #1;
        t1 = cyc;
        chk("start_done_low", done, 1'b0);
        chk("start_ar_valid", ar_valid, l >= 64'd8);
        @(posedge aclk); #1;
        en = 0;
        k = 0;
        while (!done && k < 2000) begin
            @(posedge aclk); #1;
            k++;
        end
        chk("done_wait", done, 1'b1);
        done_cyc = cyc;
    endtask

    int t1, dc, k;
    initial begin
        aresetn = 0; en = 0; src_addr = '0; dest_addr = '0; length = '0;
        // en pulse while in reset must be ignored
        repeat (2) @(posedge aclk);
        #1;
        en = 1; src_addr = 64'h1000; dest_addr = 64'h2000; length = 64'd64;
        @(posedge aclk); #1;
        en = 0;
        chk("rst_done", done, 1'b1);
        chk("rst_err", err, 1'b0);
        chk("rst_valids_readies", {ar_valid, aw_valid, w_valid, r_ready, b_ready}, 5'b0);
        chk("rst_payload", {ar_addr, ar_len, aw_addr, aw_len, w_data[31:0]}, '0);
        chk("rst_state", state_dbg, 3'd0);
        #2 aresetn = 1;
        repeat (3) @(posedge aclk);
        #1;
        chk("idle_done", done, 1'b1);
        chk("idle_no_ar", ar_valid, 1'b0);

        // Single 8-beat burst, no backpressure
        exp_ar_q.push_back({64'h1000, 8'd7});
        exp_aw_q.push_back({64'h2000, 8'd7});
        push_w(0, 8);
        run_cmd(64'h1000, 64'h2000, 64'd64, t1, dc);
        chk("done_after_b", dc, b_cyc);
        chk("t1_err", err, 1'b0);

        // 25 beats with random backpressure: 16 + 9
        bp = 1;
        exp_ar_q.push_back({64'h1000, 8'd15});
        exp_ar_q.push_back({64'h1080, 8'd8});
        exp_aw_q.push_back({64'h2000, 8'd15});
        exp_aw_q.push_back({64'h2080, 8'd8});
        push_w(0, 16);
        push_w(16, 9);
        run_cmd(64'h1000, 64'h2000, 64'd200, t1, dc);
        chk("t2_err", err, 1'b0);
        bp = 0;

        // 4 KiB page split on source
        exp_ar_q.push_back({64'h0FC0, 8'd7});
        exp_ar_q.push_back({64'h1000, 8'd7});
        exp_aw_q.push_back({64'h5000, 8'd7});
        exp_aw_q.push_back({64'h5040, 8'd7});
        push_w(0, 8);
        push_w(8, 8);
        run_cmd(64'h0FC0, 64'h5000, 64'd128, t1, dc);
        chk("t3_err", err, 1'b0);

        // Zero-beat commands: done low for exactly one cycle
        run_cmd(64'h1000, 64'h2000, 64'd0, t1, dc);
        chk("len0_one_cycle", dc - t1, 1);
        run_cmd(64'h1000, 64'h2000, 64'd7, t1, dc);
        chk("len7_one_cycle", dc - t1, 1);

        // Error response on read beat 3: drain, no write, err sticky
        err_beat = rd_beats + 3;
        exp_ar_q.push_back({64'h1000, 8'd7});
        run_cmd(64'h1000, 64'h2000, 64'd64, t1, dc);
        chk("rerr_err", err, 1'b1);
        err_beat = -1;
        run_cmd(64'h40, 64'h80, 64'd0, t1, dc);
        chk("err_cleared", err, 1'b0);

        // Reset asserted during the write burst
        exp_ar_q.push_back({64'h1000, 8'd7});
        exp_aw_q.push_back({64'h2000, 8'd7});
        push_w(0, 8);
        cmd_src = 64'h1000;
        src_addr = 64'h1000; dest_addr = 64'h2000; length = 64'd64; en = 1;
        @(posedge aclk); #1;
        en = 0;
        k = 0;
        while (!w_valid && k < 200) begin
            @(posedge aclk); #1;
            k++;
        end
        chk("reach_w", w_valid, 1'b1);
        #1 aresetn = 0;
        #1;
        chk("midw_rst_valids", {ar_valid, aw_valid, w_valid, r_ready, b_ready}, 5'b0);
        chk("midw_rst_done", done, 1'b1);
        exp_w_q.delete();
        repeat (2) @(posedge aclk);
        #3 aresetn = 1;
        repeat (3) @(posedge aclk);
        #1;
        chk("post_rst_done", done, 1'b1);

        chk("ar_q_empty", exp_ar_q.size(), 0);
        chk("aw_q_empty", exp_aw_q.size(), 0);
        chk("w_q_empty", exp_w_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
